// File: rtl/ac_pkg.sv
// ac_pkg: shared state encoding and default widths for the access-control output stage
package ac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ac_out_state_e;
  localparam int AC_DIM_WIDTH = 16;
  localparam int AC_DATA_WIDTH = 24;
endpackage

// File: rtl/ac_out_fifo.sv
// ac_out_fifo: synchronous FIFO (clk, rst_n, push/wdata, pop/rdata, full/empty), head readable one cycle after the push
module ac_out_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic we, re;
  assign we = push && !full;
  assign re = pop && !empty;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (re) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (we) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/ac_out_packer.sv
// ac_out_packer: frames up-sampled pixels (us_pix_*) onto AXI-Stream (m_axis_*) per cfg dims, with busy/cfg_err/interrupt_updone status
module ac_out_packer
  import ac_pkg::*;
#(
  parameter int DATA_WIDTH = AC_DATA_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int DIM_WIDTH  = AC_DIM_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [DIM_WIDTH-1:0]    cfg_dst_width,
  input  logic [DIM_WIDTH-1:0]    cfg_dst_height,
  input  logic                    irq_clr,
  input  logic                    us_pix_valid,
  input  logic [DATA_WIDTH-1:0]   us_pix_data,
  output logic                    us_pix_ready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    cfg_err,
  output logic                    interrupt_updone
);
  localparam int TW = 2 * DIM_WIDTH;
  ac_out_state_e state, state_nxt;
  logic [DIM_WIDTH-1:0] w, h, col, row;
  logic [TW-1:0] total, in_cnt;
  logic full, empty, push, pop, start_ok, done, col_end;
  ac_out_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .wdata(us_pix_data),
    .pop(pop), .rdata(m_axis_tdata), .full(full), .empty(empty)
  );
  assign start_ok = state == IDLE && cfg_start && |cfg_dst_width && |cfg_dst_height;
  assign us_pix_ready = state == RUN && !full && in_cnt < total;
  assign push = us_pix_valid && us_pix_ready;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign col_end = col == w - DIM_WIDTH'(1);
  assign done = state == DRAIN && pop && col_end && row == h - DIM_WIDTH'(1);
  assign busy = state != IDLE;
  assign m_axis_tvalid = !empty;
  assign m_axis_tkeep = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign m_axis_tuser = busy && m_axis_tvalid && row == '0 && col == '0;
  assign m_axis_tlast = m_axis_tvalid && col_end;
  // DRAIN is entered on the edge of the final push so the last pop always happens in DRAIN
  always_comb
    state_nxt = start_ok ? RUN :
                (state == RUN && push && in_cnt + TW'(1) == total) ? DRAIN :
                done ? IDLE : state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      total <= '0;
      in_cnt <= '0;
      col <= '0;
      row <= '0;
      cfg_err <= 1'b0;
      interrupt_updone <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        w <= cfg_dst_width;
        h <= cfg_dst_height;
        total <= TW'(cfg_dst_width) * TW'(cfg_dst_height);
        in_cnt <= '0;
        col <= '0;
        row <= '0;
      end else begin
        if (push) in_cnt <= in_cnt + TW'(1);
        if (pop) begin
          col <= col_end ? '0 : col + DIM_WIDTH'(1);
          if (col_end) row <= row + DIM_WIDTH'(1);
        end
      end
      if (state == IDLE && cfg_start) cfg_err <= !start_ok;
      interrupt_updone <= done || (interrupt_updone && !irq_clr);
    end
  end
endmodule
